// File: rtl/gpu_bus_bridge.sv
// CPU-side front end for the graphics card: queues VRAM-window byte writes in a
// small FIFO for the card's write port and holds the GPU mode word written over I/O.
module gpu_bus_bridge #(
    parameter logic [15:0] VRAM_BASE   = 16'hC000,
    parameter logic [15:0] VRAM_SIZE   = 16'h1000,
    parameter logic [7:0]  GPU_IO_PORT = 8'h10,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   bus_address,
    input  logic [15:0]                   bus_wdata,
    input  logic                          bus_mem_write,
    input  logic                          bus_io_write,
    output logic                          bus_stall,
    output logic [15:0]                   io_data,
    output logic [15:0]                   cpu_write_address,
    output logic [7:0]                    cpu_write_data,
    output logic                          cpu_write_valid,
    input  logic                          cpu_write_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [16:0]     diff;
    logic            hit, push, pop;

    // 17-bit difference so addresses below the base cannot wrap into the window
    assign diff = {1'b0, bus_address} - {1'b0, VRAM_BASE};
    assign hit  = (bus_address >= VRAM_BASE) && (diff < {1'b0, VRAM_SIZE});

    assign bus_stall       = (count == CW'(FIFO_DEPTH));
    assign cpu_write_valid = (count != '0);
    assign fifo_count      = count;

    assign push = bus_mem_write && hit && !bus_stall;
    assign pop  = cpu_write_valid && cpu_write_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: diff[15:0], data: bus_wdata[7:0]};
    end

    always_comb begin
        head = '0;
        if (cpu_write_valid) head = mem[rd_ptr];
    end

    assign cpu_write_address = head.addr;
    assign cpu_write_data    = head.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 io_data <= '0;
        else if (bus_io_write && bus_address[7:0] == GPU_IO_PORT) io_data <= bus_wdata;
    end
endmodule

// File: tb/tb_gpu_bus_bridge.sv
// Scoreboard bench for gpu_bus_bridge: directed writes push expected head entries,
// a negedge monitor pops and compares on every consumer handshake.
module tb_gpu_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_address = '0;
    logic [15:0] bus_wdata = '0;
    logic        bus_mem_write = 1'b0;
    logic        bus_io_write = 1'b0;
    logic        bus_stall;
    logic [15:0] io_data;
    logic [15:0] cpu_write_address;
    logic [7:0]  cpu_write_data;
    logic        cpu_write_valid;
    logic        cpu_write_ready = 1'b0;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];

    gpu_bus_bridge dut (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_mem_write(bus_mem_write), .bus_io_write(bus_io_write),
        .bus_stall(bus_stall), .io_data(io_data),
        .cpu_write_address(cpu_write_address), .cpu_write_data(cpu_write_data),
        .cpu_write_valid(cpu_write_valid), .cpu_write_ready(cpu_write_ready),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [15:0] off, input logic [7:0] d);
        sb.push_back({off, d});
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
        bus_address   = a;
        bus_wdata     = {8'h00, d};
        bus_mem_write = 1'b1;
        tick();
        bus_mem_write = 1'b0;
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [15:0] d);
        bus_address  = {8'h00, port};
        bus_wdata    = d;
        bus_io_write = 1'b1;
        tick();
        bus_io_write = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        cpu_write_ready = 1'b1;
        while (fifo_count != 0 && n < 20) begin
            tick();
            n++;
        end
        cpu_write_ready = 1'b0;
        chk("drain_empty", fifo_count, 0);
    endtask

    // Monitor: the values seen at negedge are the ones the next rising edge consumes
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_write_valid && cpu_write_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h/%0h expected no entry",
                             cpu_write_address, cpu_write_data);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    chk("pop_addr", cpu_write_address, e[23:8]);
                    chk("pop_data", cpu_write_data, e[7:0]);
                end
            end else if (!cpu_write_valid) begin
                chk("empty_head", {cpu_write_address, cpu_write_data}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        tick();
        tick();
        chk("rst_io", io_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", cpu_write_valid, 0);
        chk("rst_stall", bus_stall, 0);
        chk("rst_head", {cpu_write_address, cpu_write_data}, 0);
        rst = 1'b0;

        // asynchronous reset with 3 queued entries
        mem_wr(16'hC001, 8'h01);
        mem_wr(16'hC002, 8'h02);
        mem_wr(16'hC003, 8'h03);
        chk("pre_rst_count", fifo_count, 3);
        #3 rst = 1'b1;
        #1;
        chk("arst_count", fifo_count, 0);
        chk("arst_valid", cpu_write_valid, 0);
        chk("arst_head", {cpu_write_address, cpu_write_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_wr(16'hC005, 8'hAA);
        exp_push(16'h0005, 8'hAA);
        chk("post_rst_valid", cpu_write_valid, 1);
        chk("post_rst_addr", cpu_write_address, 16'h0005);
        chk("post_rst_data", cpu_write_data, 8'hAA);
        drain();

        // window edges
        mem_wr(16'hBFFF, 8'h11);
        mem_wr(16'hC000, 8'h22);
        exp_push(16'h0000, 8'h22);
        mem_wr(16'hCFFF, 8'h33);
        exp_push(16'h0FFF, 8'h33);
        mem_wr(16'hD000, 8'h44);
        chk("window_count", fifo_count, 2);
        drain();

        // full / stall with a held write
        for (int i = 0; i < 8; i++) begin
            mem_wr(16'hC100 + 16'(i), 8'h50 + 8'(i));
            exp_push(16'h0100 + 16'(i), 8'h50 + 8'(i));
        end
        chk("full_stall", bus_stall, 1);
        chk("full_count", fifo_count, 8);
        bus_address = 16'hC1FF;
        bus_wdata = 16'h0099;
        bus_mem_write = 1'b1;
        tick();
        chk("held_count", fifo_count, 8);
        cpu_write_ready = 1'b1;
        tick();
        cpu_write_ready = 1'b0;
        chk("pop_full_count", fifo_count, 7);
        chk("pop_full_stall", bus_stall, 0);
        tick();
        bus_mem_write = 1'b0;
        exp_push(16'h01FF, 8'h99);
        chk("held_accept_count", fifo_count, 8);
        drain();

        // sustained push + pop
        cpu_write_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus_address = 16'hC200 + 16'(i);
            bus_wdata = {8'h00, 8'(i * 7 + 3)};
            bus_mem_write = 1'b1;
            exp_push(16'h0200 + 16'(i), 8'(i * 7 + 3));
            tick();
            chk("stream_count", fifo_count, 1);
            chk("stream_stall", bus_stall, 0);
        end
        bus_mem_write = 1'b0;
        tick();
        cpu_write_ready = 1'b0;
        chk("stream_done", fifo_count, 0);

        // I/O register
        io_wr(8'h10, 16'h1234);
        chk("io_write", io_data, 16'h1234);
        io_wr(8'h11, 16'h5678);
        chk("io_other_port", io_data, 16'h1234);
        bus_address = 16'hC010;
        bus_wdata = 16'hABCD;
        bus_mem_write = 1'b1;
        bus_io_write = 1'b1;
        exp_push(16'h0010, 8'hCD);
        tick();
        bus_mem_write = 1'b0;
        bus_io_write = 1'b0;
        chk("both_io", io_data, 16'hABCD);
        chk("both_count", fifo_count, 1);
        drain();

        // pointer wrap bursts
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 5; k++) begin
                mem_wr(16'hC000 + 16'(b * 37 + k), 8'(b * 5 + k));
                exp_push(16'(b * 37 + k), 8'(b * 5 + k));
            end
            drain();
        end

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
